// File: rtl/avalon_mem_if_responder.sv
// Avalon-MM responder that terminates an avalon_mem_if bank with on-chip RAM (burst rd/wr, byte enables).
// Latency: readdatavalid RD_LATENCY cycles after each beat is issued; read bursts issue one beat per cycle.
// Backpressure: waitrequest high while a read burst issues; AVALON_MEM_IF_RESPONDER_RANDOM_WAIT_EN adds ~1/8 random stalls.
module avalon_mem_if_responder #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int RD_LATENCY      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         waitrequest,
  input  logic                         read,
  input  logic                         write,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [BURST_CNT_WIDTH-1:0]   burstcount,
  input  logic [DATA_WIDTH-1:0]        writedata,
  input  logic [DATA_WIDTH/8-1:0]      byteenable,
  output logic [DATA_WIDTH-1:0]        readdata,
  output logic                         readdatavalid,
  output logic                         protocol_err
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;
  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE   = BURST_CNT_WIDTH'(1);
  localparam logic [BURST_CNT_WIDTH-1:0] BC_MAX   = BURST_CNT_WIDTH'(1) << (BURST_CNT_WIDTH - 1);
  localparam logic [MEM_DEPTH_LOG2-1:0]  ADDR_ONE = MEM_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [BURST_CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [MEM_DEPTH_LOG2-1:0]   baddr_q, baddr_d;
  logic                        wait_q, wait_d;
  logic                        perr_q, perr_d;
  logic                        rand_wait_d;

  logic [MEM_DEPTH_LOG2-1:0]   cmd_addr;
  logic [BURST_CNT_WIDTH-1:0]  bc_norm;
  logic                        bc_err;
  logic                        wr_en, rd_en;
  logic [MEM_DEPTH_LOG2-1:0]   wr_addr, rd_addr;
  logic                        unused_addr_hi;

  // RAM contents rely on the device's zero power-up state; reset never touches them.
  logic [DATA_WIDTH-1:0]       mem_q   [MEM_WORDS];
  logic [DATA_WIDTH-1:0]       dpipe_q [RD_LATENCY];
  logic [RD_LATENCY-1:0]       rvld_q;

  // Only the low address bits index the RAM; the rest of the word address is ignored.
  assign cmd_addr       = address[MEM_DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  // Burst length normalisation: zero becomes one beat, oversize clamps to the legal maximum.
  always_comb begin
    bc_norm = burstcount;
    bc_err  = 1'b0;
    if (burstcount == '0) begin
      bc_norm = BC_ONE;
      bc_err  = 1'b1;
    end else if (burstcount > BC_MAX) begin
      bc_norm = BC_MAX;
      bc_err  = 1'b1;
    end
  end

  // Next-state logic plus the RAM read/write strobes for the current cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    baddr_d = baddr_q;
    perr_d  = perr_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = baddr_q;
    rd_addr = baddr_q;
    case (state_q)
      ST_IDLE: begin
        if (!wait_q) begin
          // A simultaneous read+write keeps the write and drops the read.
          if (write) begin
            wr_en   = 1'b1;
            wr_addr = cmd_addr;
            if (read || bc_err) perr_d = 1'b1;
            if (bc_norm != BC_ONE) begin
              rem_d   = bc_norm - BC_ONE;
              baddr_d = cmd_addr + ADDR_ONE;
              state_d = ST_WR_BURST;
            end
          end else if (read) begin
            rd_en   = 1'b1;
            rd_addr = cmd_addr;
            if (bc_err) perr_d = 1'b1;
            if (bc_norm != BC_ONE) begin
              rem_d   = bc_norm - BC_ONE;
              baddr_d = cmd_addr + ADDR_ONE;
              state_d = ST_RD_BURST;
            end
          end
        end
      end
      ST_WR_BURST: begin
        if (read) perr_d = 1'b1;
        if (write && !wait_q) begin
          wr_en   = 1'b1;
          baddr_d = baddr_q + ADDR_ONE;
          rem_d   = rem_q - BC_ONE;
          if (rem_q == BC_ONE) state_d = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        rd_en   = 1'b1;
        baddr_d = baddr_q + ADDR_ONE;
        rem_d   = rem_q - BC_ONE;
        if (rem_q == BC_ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    wait_d = (state_d == ST_RD_BURST) || rand_wait_d;
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      baddr_q <= '0;
      wait_q  <= 1'b1;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      baddr_q <= baddr_d;
      wait_q  <= wait_d;
      perr_q  <= perr_d;
    end
  end

`ifdef AVALON_MEM_IF_RESPONDER_RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign rand_wait_d = (lfsr_d[2:0] == 3'b000);

  // Free-running stall generator; the stall it produces lines up with the registered waitrequest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign rand_wait_d = 1'b0;
`endif

  // RAM: byte-masked write port and registered read port (read-before-write on the same address).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem_q[wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
    if (rd_en) dpipe_q[0] <= mem_q[rd_addr];
    for (int i = 1; i < RD_LATENCY; i++) dpipe_q[i] <= dpipe_q[i-1];
  end

  // Valid shift register; async reset flushes in-flight beats immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvld_q <= '0;
    end else begin
      rvld_q[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) rvld_q[i] <= rvld_q[i-1];
    end
  end

  assign waitrequest   = wait_q;
  assign protocol_err  = perr_q;
  assign readdatavalid = rvld_q[RD_LATENCY-1];
  assign readdata      = rvld_q[RD_LATENCY-1] ? dpipe_q[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_avalon_mem_if_responder.sv
// Bench for avalon_mem_if_responder: directed scenarios plus randomized traffic against a word-array model.
// Expected read beats (cycle and data) are derived from the model at command acceptance time.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_avalon_mem_if_responder;
  localparam int AW = 27, DW = 512, BW = 7, ML = 10, RL = 2;
  localparam int BEW = DW / 8, DEPTH = 1 << ML;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic waitrequest, read, write, readdatavalid, protocol_err;
  logic [AW-1:0]  address;
  logic [BW-1:0]  burstcount;
  logic [DW-1:0]  writedata, readdata;
  logic [BEW-1:0] byteenable;

  avalon_mem_if_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
                            .MEM_DEPTH_LOG2(ML), .RD_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .read(read), .write(write),
    .address(address), .burstcount(burstcount), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid), .protocol_err(protocol_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vecs = 0, errs = 0;
  logic [DW-1:0]  mem_m [DEPTH];
  logic [DW-1:0]  bdat  [64];
  logic [BEW-1:0] bbe   [64];
  int             exp_cyc[$], obs_cyc[$];
  logic [DW-1:0]  exp_dat[$], obs_dat[$];

  // Passive monitor: log every returned beat with its cycle number.
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_dat.push_back(readdata);
    end
  end

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    for (int b = 0; b < BEW; b++) if (be[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Wait (bounded) for waitrequest low with the command already on the bus.
  task automatic wait_accept(input string what);
    int n = 0;
    while (waitrequest !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vecs++; errs++;
      $display("FAIL %s_timeout: waitrequest=%b after 200 cycles, required 0", what, waitrequest);
    end
  endtask

  task automatic do_write(input int a, input int n, input int bcf, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && gaps && $urandom_range(0, 2) == 0) begin
        write = 1'b0;
        @(negedge clk);
      end
      write = 1'b1;
      if (k == 0) begin
        address = AW'(a); burstcount = BW'(bcf);
      end else begin
        address = AW'($urandom); burstcount = BW'($urandom);
      end
      writedata = bdat[k]; byteenable = bbe[k];
      wait_accept("write");
      model_write((a + k) % DEPTH, bdat[k], bbe[k]);
      @(negedge clk);
    end
    write = 1'b0;
  endtask

  task automatic do_read(input int a, input int n, input int bcf, output int t);
    read = 1'b1; address = AW'(a); burstcount = BW'(bcf);
    wait_accept("read");
    t = cyc;
    for (int k = 0; k < n; k++) begin
      exp_cyc.push_back(t + RL + k);
      exp_dat.push_back(mem_m[(a + k) % DEPTH]);
    end
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic fill(input bit rnd);
    for (int k = 0; k < 64; k++) begin
      bdat[k] = rnd ? rnd_word() : DW'(k + 1);
      bbe[k]  = '1;
    end
  endtask

  task automatic test_reset();
    read = 0; write = 0; address = '0; burstcount = '0; writedata = '0; byteenable = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (2) @(negedge clk);
    vecs++; if (waitrequest !== 1'b1) begin errs++; $display("FAIL reset_wait: %b, required 1", waitrequest); end
    vecs++; if (readdatavalid !== 1'b0) begin errs++; $display("FAIL reset_rdv: %b, required 0", readdatavalid); end
    vecs++; if (readdata !== '0) begin errs++; $display("FAIL reset_rdata: %h, required 0", readdata); end
    vecs++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL reset_perr: %b, required 0", protocol_err); end
    reset = 1'b0;
    #1;
    vecs++; if (waitrequest !== 1'b1) begin errs++; $display("FAIL release_wait_pre: %b, required 1", waitrequest); end
    @(negedge clk);
    vecs++; if (waitrequest !== 1'b0) begin errs++; $display("FAIL release_wait_post: %b, required 0", waitrequest); end
  endtask

  task automatic test_single();
    int t;
    fill(0);
    bdat[0] = {64{8'hA5}};
    do_write(16'h10, 1, 1, 0);
    do_read(16'h10, 1, 1, t);
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL single_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL single_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
    vecs++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL single_perr: %b, required 0", protocol_err); end
  endtask

  task automatic test_burst();
    int t;
    fill(0);
    do_write(16'h20, 4, 4, 1);
    do_read(16'h20, 4, 4, t);
    for (int i = 1; i <= 3; i++) begin
      vecs++; if (waitrequest !== 1'b1) begin errs++; $display("FAIL burst_wait_T+%0d: %b, required 1", i, waitrequest); end
      @(negedge clk);
    end
    vecs++; if (waitrequest !== 1'b0) begin errs++; $display("FAIL burst_wait_T+4: %b, required 0", waitrequest); end
    repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL burst_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL burst_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
  endtask

  task automatic test_byteenable();
    int t;
    logic [DW-1:0] want;
    fill(0);
    bdat[0] = '1;
    do_write(16'h30, 1, 1, 0);
    bdat[0] = '0; bbe[0] = BEW'(1);
    do_write(16'h30, 1, 1, 0);
    do_read(16'h30, 1, 1, t);
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    want = {{(BEW-1){8'hFF}}, 8'h00};
    vecs++; if (obs_cyc.size() !== 1) begin errs++; $display("FAIL be_count: %0d beats, required 1", obs_cyc.size()); end
    else if (obs_dat[0] !== want || obs_cyc[0] !== exp_cyc[0]) begin errs++; $display("FAIL be_data: cycle %0d data %h, required cycle %0d data %h", obs_cyc[0], obs_dat[0], exp_cyc[0], want); end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
  endtask

  task automatic test_wrap();
    int t;
    fill(0);
    bdat[0] = DW'(7); bdat[1] = DW'(8);
    do_write(16'h3FF, 2, 2, 0);
    do_read(16'h3FF, 1, 1, t);
    do_read(16'h000, 1, 1, t);
    do_read(16'h7FF, 2, 2, t);
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL wrap_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL wrap_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
  endtask

  task automatic test_back_to_back();
    int t;
    for (int i = 0; i < 6; i++) do_read($urandom_range(0, 63), 1, 1, t);
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL b2b_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL b2b_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
  endtask

  task automatic test_errors();
    int t;
    vecs++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL err_pre: %b, required 0", protocol_err); end
    do_read(16'h10, 1, 0, t);
    vecs++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL err_bc0: %b, required 1", protocol_err); end
    // read and write together: only the write happens
    read = 1'b1; write = 1'b1; address = AW'(16'h40); burstcount = BW'(1);
    writedata = rnd_word(); byteenable = '1;
    wait_accept("rdwr");
    model_write(16'h40, writedata, byteenable);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    do_read(16'h40, 1, 1, t);
    do_read(16'h3F0, 64, 100, t);
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL err_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL err_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
    vecs++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL err_sticky: %b, required 1", protocol_err); end
  endtask

  task automatic test_reset_mid();
    int t;
    fill(1);
    do_write(16'h20, 8, 8, 0);
    do_read(16'h20, 8, 8, t);
    while (cyc < t + RL + 3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vecs++; if (readdatavalid !== 1'b0) begin errs++; $display("FAIL mid_rdv: %b, required 0", readdatavalid); end
    vecs++; if (waitrequest !== 1'b1) begin errs++; $display("FAIL mid_wait: %b, required 1", waitrequest); end
    vecs++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL mid_perr: %b, required 0", protocol_err); end
    vecs++; if (obs_cyc.size() !== 4) begin errs++; $display("FAIL mid_count: %0d beats before reset, required 4", obs_cyc.size()); end
    for (int i = 0; i < 4 && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL mid_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vecs++; if (waitrequest !== 1'b0) begin errs++; $display("FAIL mid_release_wait: %b, required 0", waitrequest); end
    vecs++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL mid_release_perr: %b, required 0", protocol_err); end
    do_read(16'h20, 8, 8, t);
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL reread_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL reread_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
  endtask

  task automatic test_random();
    int t, a, n;
    for (int it = 0; it < 40; it++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1) : $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          bdat[k] = rnd_word();
          bbe[k]  = {$urandom, $urandom};
        end
        do_write(a, n, n, 1);
      end else begin
        n = $urandom_range(1, 8);
        do_read(a, n, n, t);
      end
    end
    wait_accept("drain"); repeat (RL + 3) @(negedge clk);
    vecs++; if (obs_cyc.size() !== exp_cyc.size()) begin errs++; $display("FAIL rand_count: %0d beats, required %0d", obs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      vecs++;
      if (obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin errs++; $display("FAIL rand_beat%0d: cycle %0d data %h, required cycle %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]); end
    end
    obs_cyc.delete(); obs_dat.delete(); exp_cyc.delete(); exp_dat.delete();
    vecs++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL rand_perr: %b, required 0", protocol_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_byteenable();
    test_wrap();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    errs++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
